buttons_poll_ctrl: RTL and testbench

- Periodically polls the 12-bit buttons PIO input slave (Avalon-MM, data at address 0, registered readdata) through its own Avalon-MM master port.
- Debounces each bit and captures press edges.
- Exposes debounced state, press-edge capture, interrupt mask and control to the CPU through an Avalon-MM slave with a level IRQ.
- Sits between the buttons PIO and the Nios interconnect, so software no longer polls raw switch levels.

---
 rtl/buttons_poll_ctrl.sv | 145 ++++++++++++++
 tb/tb_buttons_poll_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/buttons_poll_ctrl.sv
// Polls the buttons PIO over an Avalon-MM master, debounces each bit, captures
// press edges and exposes state/mask/edge/ctrl to the CPU with a level irq.
//
// state  | meaning
// IDLE   | waiting for the poll tick
// REQ    | m_read pulse to the PIO, address 0
// CAPT   | PIO readdata valid, latched into sample
// UPDATE | debounce and edge capture applied
module buttons_poll_ctrl #(
  parameter int WIDTH      = 12,
  parameter int POLL_DIV   = 50000,
  parameter int STABLE_CNT = 4,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [1:0]  m_address,
  output logic        m_read,
  input  logic [31:0] m_readdata,
  input  logic [1:0]  s_address,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic        irq
);

  localparam int TW = $clog2(POLL_DIV);
  localparam logic [TW-1:0] TIMER_LAST = TW'(POLL_DIV - 1);
  localparam logic [3:0] CNT_LAST = 4'(STABLE_CNT - 1);
  localparam logic [WIDTH-1:0] RELEASED = {WIDTH{ACTIVE_LOW}};
  localparam logic PRESSED = ~ACTIVE_LOW;

  typedef enum logic [1:0] {IDLE, REQ, CAPT, UPDATE} fsm_t;

  fsm_t fsm, fsm_nxt;
  logic [TW-1:0] timer;
  logic tick;
  logic enable;
  logic [WIDTH-1:0] sample, db_state, db_state_nxt, mask, edge_cap, edge_nxt, press;
  logic [WIDTH-1:0][3:0] cnt, cnt_nxt;
  logic wr_mask, wr_edge, wr_ctrl, busy;
  logic [31:0] rd_mux;
  logic unused_bits;

  assign m_address = 2'd0;
  assign tick = enable && (timer == TIMER_LAST);
  assign busy = (fsm != IDLE);
  assign irq = |(edge_cap & mask);
  assign wr_mask = s_write && (s_address == 2'd1);
  assign wr_edge = s_write && (s_address == 2'd2);
  assign wr_ctrl = s_write && (s_address == 2'd3);
  assign unused_bits = ^{m_readdata[31:WIDTH], s_writedata[31:WIDTH]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer <= '0;
    end else if (!enable || tick) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm    <= IDLE;
      m_read <= 1'b0;
    end else begin
      fsm    <= fsm_nxt;
      m_read <= (fsm_nxt == REQ);
    end
  end

  always_comb begin
    fsm_nxt = fsm;
    case (fsm)
      IDLE:    if (tick) fsm_nxt = REQ;
      REQ:     fsm_nxt = CAPT;
      CAPT:    fsm_nxt = UPDATE;
      UPDATE:  fsm_nxt = IDLE;
      default: fsm_nxt = IDLE;
    endcase
  end

  // A bit must differ from the debounced state on STABLE_CNT consecutive polls to flip.
  always_comb begin
    db_state_nxt = db_state;
    cnt_nxt      = cnt;
    press        = '0;
    if (fsm == UPDATE) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sample[i] == db_state[i]) begin
          cnt_nxt[i] = 4'd0;
        end else if (cnt[i] == CNT_LAST) begin
          db_state_nxt[i] = sample[i];
          cnt_nxt[i]      = 4'd0;
          press[i]        = (sample[i] == PRESSED);
        end else begin
          cnt_nxt[i] = cnt[i] + 4'd1;
        end
      end
    end
  end

  // New press edges win over a same-cycle write-1-to-clear.
  assign edge_nxt = (edge_cap & ~(wr_edge ? s_writedata[WIDTH-1:0] : '0)) | press;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sample   <= RELEASED;
      db_state <= RELEASED;
      cnt      <= '0;
      edge_cap <= '0;
      mask     <= '0;
      enable   <= 1'b0;
    end else begin
      if (fsm == CAPT) sample <= m_readdata[WIDTH-1:0];
      db_state <= db_state_nxt;
      cnt      <= cnt_nxt;
      edge_cap <= edge_nxt;
      if (wr_mask) mask <= s_writedata[WIDTH-1:0];
      if (wr_ctrl) enable <= s_writedata[0];
    end
  end

  always_comb begin
    rd_mux = '0;
    case (s_address)
      2'd0:    rd_mux[WIDTH-1:0] = db_state;
      2'd1:    rd_mux[WIDTH-1:0] = mask;
      2'd2:    rd_mux[WIDTH-1:0] = edge_cap;
      default: rd_mux[1:0] = {busy, enable};
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_readdata <= '0;
    end else if (s_read) begin
      s_readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_buttons_poll_ctrl.sv
// Directed bench for buttons_poll_ctrl with a registered PIO model on the master port.
module tb_buttons_poll_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  m_address;
  logic        m_read;
  logic [31:0] m_readdata;
  logic [1:0]  s_address = 2'd0;
  logic        s_read = 1'b0;
  logic        s_write = 1'b0;
  logic [31:0] s_writedata = 32'd0;
  logic [31:0] s_readdata;
  logic        irq;
  logic [11:0] in_port = 12'hFFF;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  buttons_poll_ctrl #(
    .WIDTH(12), .POLL_DIV(8), .STABLE_CNT(4), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .m_address(m_address), .m_read(m_read), .m_readdata(m_readdata),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_readdata(s_readdata), .irq(irq)
  );

  // Buttons PIO: registered readdata, junk in the upper bits the DUT must ignore.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) m_readdata <= 32'd0;
    else if (m_read) m_readdata <= (m_address == 2'd0) ? {20'hABCDE, in_port} : 32'd0;
  end

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    s_address = a; s_writedata = d; s_write = 1'b1;
    @(negedge clk);
    s_write = 1'b0; s_writedata = 32'd0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    s_address = a; s_read = 1'b1;
    @(negedge clk);
    d = s_readdata; s_read = 1'b0;
  endtask

  task automatic wait_mread(output int n);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (m_read === 1'b1) begin n = i; break; end
    end
    n_cmp++;
    if (n == 0) begin n_bad++; $display("FAIL wait_mread: no m_read pulse within 40 cycles"); end
  endtask

  task automatic count_mread(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (m_read !== 1'b0) pulses++;
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    int n;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (m_read !== 1'b0) begin n_bad++; $display("FAIL rst_m_read: got %b exp 0", m_read); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL rst_irq: got %b exp 0", irq); end
    n_cmp++; if (s_readdata !== 32'd0) begin n_bad++; $display("FAIL rst_rdata: got %h exp 0", s_readdata); end
    bus_read(2'd0, d);
    n_cmp++; if (d !== 32'h0000_0FFF) begin n_bad++; $display("FAIL rst_state: got %h exp %h", d, 32'h0000_0FFF); end
    bus_read(2'd1, d);
    n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL rst_mask: got %h exp 0", d); end
    bus_read(2'd2, d);
    n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL rst_edge: got %h exp 0", d); end
    bus_read(2'd3, d);
    n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL rst_ctrl: got %h exp 0", d); end
    count_mread(30, n);
    n_cmp++; if (n != 0) begin n_bad++; $display("FAIL rst_no_poll: got %0d pulses exp 0", n); end
    bus_write(2'd3, 32'd1);
    bus_read(2'd3, d);
    n_cmp++; if (d !== 32'd1) begin n_bad++; $display("FAIL ctrl_enable_rd: got %h exp 1", d); end
    wait_mread(n);
    n_cmp++; if (m_address !== 2'd0) begin n_bad++; $display("FAIL m_address: got %0d exp 0", m_address); end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (m_read !== 1'b0) begin n_bad++; $display("FAIL midpoll_rst_m_read: got %b exp 0", m_read); end
    n_cmp++; if (s_readdata !== 32'd0) begin n_bad++; $display("FAIL midpoll_rst_rdata: got %h exp 0", s_readdata); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL midpoll_rst_irq: got %b exp 0", irq); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    bus_read(2'd3, d);
    n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL midpoll_rst_ctrl: got %h exp 0", d); end
  endtask

  task automatic test_press();
    logic [31:0] d;
    int n;
    bus_write(2'd1, 32'hFFFF_F008);
    bus_read(2'd1, d);
    n_cmp++; if (d !== 32'h0000_0008) begin n_bad++; $display("FAIL mask_rd: got %h exp %h", d, 32'h0000_0008); end
    in_port = 12'hFF7;
    bus_write(2'd3, 32'd1);
    wait_mread(n);
    n_cmp++; if (n != 8) begin n_bad++; $display("FAIL first_poll_latency: got %0d exp 8", n); end
    wait_mread(n);
    n_cmp++; if (n != 8) begin n_bad++; $display("FAIL poll_interval: got %0d exp 8", n); end
    @(negedge clk);
    n_cmp++; if (m_read !== 1'b0) begin n_bad++; $display("FAIL m_read_width: got %b exp 0", m_read); end
    repeat (2) @(negedge clk);
    wait_mread(n);
    repeat (3) @(negedge clk);
    bus_read(2'd0, d);
    n_cmp++; if (d !== 32'h0000_0FFF) begin n_bad++; $display("FAIL press_poll3_state: got %h exp %h", d, 32'h0000_0FFF); end
    bus_read(2'd2, d);
    n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL press_poll3_edge: got %h exp 0", d); end
    wait_mread(n);
    repeat (3) @(negedge clk);
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL press_irq: got %b exp 1", irq); end
    bus_read(2'd0, d);
    n_cmp++; if (d !== 32'h0000_0FF7) begin n_bad++; $display("FAIL press_state: got %h exp %h", d, 32'h0000_0FF7); end
    bus_read(2'd2, d);
    n_cmp++; if (d !== 32'h0000_0008) begin n_bad++; $display("FAIL press_edge: got %h exp %h", d, 32'h0000_0008); end
  endtask

  task automatic test_release();
    logic [31:0] d;
    int n;
    bus_write(2'd2, 32'h0000_0008);
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL clr_irq: got %b exp 0", irq); end
    bus_read(2'd2, d);
    n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL clr_edge: got %h exp 0", d); end
    in_port = 12'hFFF;
    for (int p = 0; p < 3; p++) wait_mread(n);
    repeat (3) @(negedge clk);
    bus_read(2'd0, d);
    n_cmp++; if (d !== 32'h0000_0FF7) begin n_bad++; $display("FAIL release_poll3_state: got %h exp %h", d, 32'h0000_0FF7); end
    wait_mread(n);
    repeat (3) @(negedge clk);
    bus_read(2'd0, d);
    n_cmp++; if (d !== 32'h0000_0FFF) begin n_bad++; $display("FAIL release_state: got %h exp %h", d, 32'h0000_0FFF); end
    bus_read(2'd2, d);
    n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL release_edge: got %h exp 0", d); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL release_irq: got %b exp 0", irq); end
  endtask

  task automatic test_bounce();
    logic [31:0] d;
    int n;
    bus_write(2'd1, 32'h0000_0FFF);
    for (int k = 0; k < 10; k++) begin
      in_port = (k % 2 == 0) ? 12'hFDF : 12'hFFF;
      wait_mread(n);
      repeat (3) @(negedge clk);
      n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL bounce_irq poll %0d: got %b exp 0", k, irq); end
    end
    bus_read(2'd0, d);
    n_cmp++; if (d !== 32'h0000_0FFF) begin n_bad++; $display("FAIL bounce_state: got %h exp %h", d, 32'h0000_0FFF); end
    bus_read(2'd2, d);
    n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL bounce_edge: got %h exp 0", d); end
  endtask

  task automatic test_w1c_race();
    logic [31:0] d;
    int n;
    in_port = 12'hFF7;
    for (int p = 0; p < 4; p++) wait_mread(n);
    repeat (2) @(negedge clk);
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL race_pre_irq: got %b exp 0", irq); end
    bus_write(2'd2, 32'h0000_0008);
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL race_irq: got %b exp 1", irq); end
    bus_read(2'd2, d);
    n_cmp++; if (d !== 32'h0000_0008) begin n_bad++; $display("FAIL race_edge: got %h exp %h", d, 32'h0000_0008); end
    bus_read(2'd0, d);
    n_cmp++; if (d !== 32'h0000_0FF7) begin n_bad++; $display("FAIL race_state: got %h exp %h", d, 32'h0000_0FF7); end
    bus_write(2'd2, 32'h0000_0008);
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL w1c_irq_drop: got %b exp 0", irq); end
    bus_read(2'd2, d);
    n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL w1c_edge: got %h exp 0", d); end
  endtask

  task automatic test_disable_midpoll();
    logic [31:0] d;
    int n;
    wait_mread(n);
    bus_write(2'd3, 32'd0);
    bus_read(2'd3, d);
    n_cmp++; if (d !== 32'd2) begin n_bad++; $display("FAIL dis_capt_ctrl: got %h exp 2", d); end
    bus_read(2'd3, d);
    n_cmp++; if (d !== 32'd2) begin n_bad++; $display("FAIL dis_update_ctrl: got %h exp 2", d); end
    bus_read(2'd3, d);
    n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL dis_idle_ctrl: got %h exp 0", d); end
    count_mread(100, n);
    n_cmp++; if (n != 0) begin n_bad++; $display("FAIL dis_no_poll: got %0d pulses exp 0", n); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_press();
    test_release();
    test_bounce();
    test_w1c_race();
    test_disable_midpoll();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
